// File: rtl/debounce_pkg.sv
// Shared debounce timing constants and the per-bit output record used by
// the switch debouncer and its per-bit slice.
package debounce_pkg;

  localparam int unsigned CLK_HZ                = 100_000_000;
  localparam int unsigned DEBOUNCE_MS           = 10;
  localparam int unsigned DEFAULT_STABLE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

  typedef struct packed {
    logic clean;
    logic rise;
    logic fall;
  } bit_out_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter, clean level and
// single-cycle edge strobes. All outputs are registered.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     raw,
  output bit_out_t q
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      q   <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      q.rise <= 1'b0;
      q.fall <= 1'b0;
      if (s2 == q.clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // With a 1-cycle window a strobe could otherwise repeat back to back;
        // hold the count one cycle so strobes stay isolated.
        if (!(q.rise || q.fall)) begin
          q.clean <= s2;
          q.rise  <= s2;
          q.fall  <= ~s2;
          cnt     <= '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a bus of raw slide switches; each bit is an independent
// debounce_bit slice producing a clean level plus rise/fall strobes.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  bit_out_t [WIDTH-1:0] bit_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .q    (bit_q[i])
    );
    assign sw_clean[i] = bit_q[i].clean;
    assign sw_rise[i]  = bit_q[i].rise;
    assign sw_fall[i]  = bit_q[i].fall;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a 4-cycle stability window.
module tb_switch_debouncer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;

  int checks   = 0;
  int failures = 0;

  switch_debouncer #(
    .WIDTH(W),
    .STABLE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [W-1:0] c, input logic [W-1:0] r,
                      input logic [W-1:0] f);
    chk({tag, ".clean"}, sw_clean, c);
    chk({tag, ".rise"},  sw_rise,  r);
    chk({tag, ".fall"},  sw_fall,  f);
  endtask

  // Drive a new raw value at a falling edge; the following rising edge is the
  // sampling edge k, so the new level shows after the sixth falling edge (k+5).
  task automatic transition(input string tag, input logic [W-1:0] raw,
                            input logic [W-1:0] old_c, input logic [W-1:0] new_c,
                            input logic [W-1:0] r, input logic [W-1:0] f);
    sw_raw = raw;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk3({tag, ".wait"}, old_c, '0, '0);
    end
    @(negedge clk);
    chk3({tag, ".edge"}, new_c, r, f);
    @(negedge clk);
    chk3({tag, ".after"}, new_c, '0, '0);
  endtask

  task automatic hold_quiet(input string tag, input int n, input logic [W-1:0] c);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk3(tag, c, '0, '0);
    end
  endtask

  initial begin
    // 1. Reset hold with all switches high, then release
    sw_raw = 8'hFF;
    rst_n  = 1'b0;
    #1;
    chk3("reset_t0", 8'h00, 8'h00, 8'h00);
    hold_quiet("reset_hold", 10, 8'h00);
    rst_n = 1'b1;
    transition("reset_release", 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);
    transition("all_fall", 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF);

    // 2. Clean step on bit 0
    transition("step_b0", 8'h01, 8'h00, 8'h01, 8'h01, 8'h00);

    // 3. Glitches on bit 3: 2 and 3 high cycles never complete the window
    sw_raw = 8'h09;
    repeat (2) @(negedge clk);
    sw_raw = 8'h01;
    hold_quiet("glitch2", 8, 8'h01);
    sw_raw = 8'h09;
    repeat (3) @(negedge clk);
    sw_raw = 8'h01;
    hold_quiet("glitch3", 8, 8'h01);

    // 4. Bounce on bit 5, 2-cycle toggles for 12 cycles, then settle high
    for (int i = 0; i < 6; i++) begin
      sw_raw = (i % 2 == 0) ? 8'h21 : 8'h01;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        chk3("bounce", 8'h01, 8'h00, 8'h00);
      end
    end
    transition("bounce_settle", 8'h21, 8'h01, 8'h21, 8'h20, 8'h00);

    // 5. Simultaneous multi-bit change
    transition("to_zero", 8'h00, 8'h21, 8'h00, 8'h00, 8'h21);
    transition("multi_rise", 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00);
    transition("multi_fall", 8'h00, 8'hA5, 8'h00, 8'h00, 8'hA5);

    // 6. Reset while bit 2 is mid-count, with bit 7 already clean high
    transition("pre_b7", 8'h80, 8'h00, 8'h80, 8'h80, 8'h00);
    sw_raw = 8'h84;
    repeat (4) @(negedge clk);
    chk3("mid_count", 8'h80, 8'h00, 8'h00);
    chk("mid_count.cnt", W'(dut.g_bit[2].u_bit.cnt), 8'd2);
    rst_n = 1'b0;
    #1;
    chk3("reset_async", 8'h00, 8'h00, 8'h00);
    chk("reset_async.cnt", W'(dut.g_bit[2].u_bit.cnt), 8'd0);
    hold_quiet("reset_mid_hold", 3, 8'h00);
    rst_n = 1'b1;
    transition("post_reset", 8'h84, 8'h00, 8'h84, 8'h84, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
